// File: rtl/fetch_prefetch_queue.sv
// Instruction fetch unit: owns the PC and keeps a small prefetch queue of {instr, pc} pairs
// ahead of decode. Redirects and reset flush the queue and drop any in-flight fetch.
module fetch_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         redirect_valid,
  input  logic [31:0]                  redirect_pc,
  output logic [31:0]                  memory_instr__address,
  output logic [31:0]                  memory_instr__write_data,
  output logic [3:0]                   memory_instr__write_enable,
  input  logic [31:0]                  memory_instr__read_data,
  output logic                         mem_req,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  out_instr,
  output logic [31:0]                  out_pc,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [31:0]   r_fetch_pc;
  logic          r_inflight;
  logic [31:0]   r_inflight_pc;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_instr_mem [DEPTH];
  logic [31:0]   r_pc_mem    [DEPTH];

  logic          w_flush;
  logic          w_pop;
  logic          w_push;
  logic          w_issue;
  logic [CW:0]   w_occ;
  logic [31:0]   w_redirect_pc;

  assign w_flush       = reset || redirect_valid;
  assign w_redirect_pc = redirect_pc & 32'hFFFF_FFFC;

  assign out_valid = (r_count != '0) && !w_flush;
  assign w_pop     = out_valid && out_ready;
  assign w_push    = r_inflight && !w_flush;

  // Occupancy counts the in-flight fetch so a response always finds a free slot.
  assign w_occ   = (CW+1)'(r_count) + (CW+1)'(r_inflight) - (CW+1)'(w_pop);
  assign w_issue = !w_flush && (w_occ < (CW+1)'(DEPTH));

  assign mem_req                    = w_issue;
  assign memory_instr__address      = r_fetch_pc;
  assign memory_instr__write_data   = 32'h0000_0000;
  assign memory_instr__write_enable = 4'b0000;

  assign out_instr = out_valid ? r_instr_mem[r_rd_ptr] : 32'h0000_0000;
  assign out_pc    = out_valid ? r_pc_mem[r_rd_ptr]    : 32'h0000_0000;
  assign count     = r_count;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr_mem[r_wr_ptr] <= memory_instr__read_data;
      r_pc_mem[r_wr_ptr]    <= r_inflight_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= 32'h0000_0000;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc <= w_redirect_pc;
      r_inflight <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CW'(1);
      end
      if (w_issue) begin
        r_fetch_pc    <= r_fetch_pc + 32'd4;
        r_inflight    <= 1'b1;
        r_inflight_pc <= r_fetch_pc;
      end else begin
        r_inflight <= 1'b0;
      end
    end
  end

endmodule
